// File: rtl/axis_arb_pkg.sv
// Shared types and constants for the frame-granular AXI-Stream arbiter.
package axis_arb_pkg;

  localparam int MAX_SRC = 8;
  localparam int IDX_W   = $clog2(MAX_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority selector: picks the first requester after
// the last-granted index, wrapping NUM_SRC-1 -> 0, as a one-hot grant plus index.
module rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_SRC-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  logic found;
  int   idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise synthesis infers a latch to hold it.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = last_i;
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      idx = (int'(last_i) + off) % NUM_SRC;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_frame_arb.sv
// Frame-granular round-robin merge of NUM_SRC AXI-Stream sources into one.
// Optional per-source completed-frame counters under AXIS_ARB_FRAME_CNT_EN.
module axis_frame_arb
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SRC    = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0]   S_AXIS_tdata,
  input  logic [NUM_SRC*DATA_WIDTH/8-1:0] S_AXIS_tkeep,
  input  logic [NUM_SRC-1:0]              S_AXIS_tlast,
  input  logic [NUM_SRC-1:0]              S_AXIS_tvalid,
  output logic [NUM_SRC-1:0]              S_AXIS_tready,
  output logic [DATA_WIDTH-1:0]           M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0]         M_AXIS_tkeep,
  output logic                            M_AXIS_tlast,
  output logic                            M_AXIS_tvalid,
  input  logic                            M_AXIS_tready,
`ifdef AXIS_ARB_FRAME_CNT_EN
  output logic [NUM_SRC*16-1:0]           frame_cnt,
`endif
  output logic [NUM_SRC-1:0]              grant
);

  localparam int KEEP_W = DATA_WIDTH / 8;

  arb_state_e         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q,  last_d;

  logic [NUM_SRC-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               frame_done;

  rr_arbiter #(.NUM_SRC(NUM_SRC)) u_rr (
    .req_i     (S_AXIS_tvalid),
    .last_i    (last_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Zero-latency path from the owner to the merged stream; silent in IDLE.
  always_comb begin
    M_AXIS_tdata  = '0;
    M_AXIS_tkeep  = '0;
    M_AXIS_tlast  = 1'b0;
    M_AXIS_tvalid = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (state_q == XFER && owner_q == IDX_W'(i)) begin
        M_AXIS_tdata  = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        M_AXIS_tkeep  = S_AXIS_tkeep[i*KEEP_W +: KEEP_W];
        M_AXIS_tlast  = S_AXIS_tlast[i];
        M_AXIS_tvalid = S_AXIS_tvalid[i];
      end
    end
  end

  assign frame_done    = M_AXIS_tvalid & M_AXIS_tready & M_AXIS_tlast;
  assign S_AXIS_tready = grant_q & {NUM_SRC{M_AXIS_tready}};
  assign grant         = grant_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|S_AXIS_tvalid) begin
          state_d = XFER;
          grant_d = arb_gnt;
          owner_d = arb_idx;
        end
      end
      XFER: begin
        if (frame_done) begin
          state_d = IDLE;
          grant_d = '0;
          last_d  = owner_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= IDX_W'(NUM_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

`ifdef AXIS_ARB_FRAME_CNT_EN
  logic [15:0] cnt_q [NUM_SRC];

  // NOTE: this small counter array is reset explicitly because software reads
  // it; large data memories would normally be left unreset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (frame_done && owner_q == IDX_W'(i)) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign frame_cnt[g*16 +: 16] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_axis_frame_arb.sv
// Randomised and directed bench for axis_frame_arb against a frame-level
// reference model (per-source beat queues plus a round-robin owner pointer).
module tb_axis_frame_arb;

  localparam int DW = 32;
  localparam int NS = 4;
  localparam int KW = DW / 8;
  localparam int QD = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS*DW-1:0] S_AXIS_tdata  = '0;
  logic [NS*KW-1:0] S_AXIS_tkeep  = '0;
  logic [NS-1:0]    S_AXIS_tlast  = '0;
  logic [NS-1:0]    S_AXIS_tvalid = '0;
  logic [NS-1:0]    S_AXIS_tready;
  logic [DW-1:0]    M_AXIS_tdata;
  logic [KW-1:0]    M_AXIS_tkeep;
  logic             M_AXIS_tlast;
  logic             M_AXIS_tvalid;
  logic             M_AXIS_tready = 1'b0;
  logic [NS-1:0]    grant;
`ifdef AXIS_ARB_FRAME_CNT_EN
  logic [NS*16-1:0] frame_cnt;
`endif

  axis_frame_arb #(.DATA_WIDTH(DW), .NUM_SRC(NS)) dut (
    .clk           (clk),
    .rst           (rst),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .S_AXIS_tkeep  (S_AXIS_tkeep),
    .S_AXIS_tlast  (S_AXIS_tlast),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tready (S_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .M_AXIS_tkeep  (M_AXIS_tkeep),
    .M_AXIS_tlast  (M_AXIS_tlast),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
`ifdef AXIS_ARB_FRAME_CNT_EN
    .frame_cnt     (frame_cnt),
`endif
    .grant         (grant)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-source pending beats (circular store) and frame-level model state.
  logic [DW-1:0] q_data [NS][QD];
  logic [KW-1:0] q_keep [NS][QD];
  logic          q_last [NS][QD];
  int            q_head [NS];
  int            q_tail [NS];
  int            m_owner = -1;
  int            m_last  = NS - 1;
  int            m_cnt   [NS];

  int            step_no = 0;
  int            beat_steps[$];
  logic [NS-1:0] gnt_order[$];
  logic [NS-1:0] prev_grant = '0;

  task automatic add_frame(input int src, input int len);
    for (int b = 0; b < len; b++) begin
      q_data[src][q_tail[src] % QD] = $urandom;
      q_keep[src][q_tail[src] % QD] = KW'($urandom);
      q_last[src][q_tail[src] % QD] = (b == len - 1);
      q_tail[src]++;
    end
  endtask

  // One clock: drive sources, check the merged stream against the model,
  // then advance the model with the handshakes that occurred at the edge.
  task automatic step(input logic [NS-1:0] en, input logic mr, input logic r);
    logic [NS-1:0] v;
    logic [NS-1:0] eg;
    logic          ev;
    int            slot;
    @(negedge clk);
    rst           = r;
    M_AXIS_tready = mr;
    for (int i = 0; i < NS; i++) begin
      v[i] = en[i] && (q_head[i] != q_tail[i]);
      S_AXIS_tvalid[i] = v[i];
      if (v[i]) begin
        slot = q_head[i] % QD;
        S_AXIS_tdata[i*DW +: DW] = q_data[i][slot];
        S_AXIS_tkeep[i*KW +: KW] = q_keep[i][slot];
        S_AXIS_tlast[i]          = q_last[i][slot];
      end else begin
        S_AXIS_tdata[i*DW +: DW] = DW'($urandom);
        S_AXIS_tkeep[i*KW +: KW] = '0;
        S_AXIS_tlast[i]          = 1'($urandom);
      end
    end
    #1;
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    ev = (m_owner >= 0) && v[m_owner];

    n_checks++;
    if (grant !== eg) $display("FAIL grant step=%0d got=%b exp=%b", step_no, grant, eg);
    else n_pass++;
    n_checks++;
    if (M_AXIS_tvalid !== ev) $display("FAIL m_tvalid step=%0d got=%b exp=%b", step_no, M_AXIS_tvalid, ev);
    else n_pass++;
    n_checks++;
    if (S_AXIS_tready !== (mr ? eg : '0))
      $display("FAIL s_tready step=%0d got=%b exp=%b", step_no, S_AXIS_tready, (mr ? eg : '0));
    else n_pass++;
    if (ev) begin
      slot = q_head[m_owner] % QD;
      n_checks++;
      if (M_AXIS_tdata !== q_data[m_owner][slot] || M_AXIS_tkeep !== q_keep[m_owner][slot] ||
          M_AXIS_tlast !== q_last[m_owner][slot])
        $display("FAIL m_beat step=%0d got=%h/%h/%b exp=%h/%h/%b", step_no, M_AXIS_tdata,
                 M_AXIS_tkeep, M_AXIS_tlast, q_data[m_owner][slot], q_keep[m_owner][slot],
                 q_last[m_owner][slot]);
      else n_pass++;
    end

    if (grant != '0 && prev_grant == '0) gnt_order.push_back(grant);
    prev_grant = grant;
    if (M_AXIS_tvalid && mr) beat_steps.push_back(step_no);

    @(posedge clk);
    step_no++;
    if (r) begin
      m_owner = -1;
      m_last  = NS - 1;
      for (int i = 0; i < NS; i++) begin
        q_head[i] = 0;
        q_tail[i] = 0;
        m_cnt[i]  = 0;
      end
    end else if (m_owner < 0) begin
      for (int k = 1; k <= NS; k++) begin
        if (m_owner < 0 && v[(m_last + k) % NS]) m_owner = (m_last + k) % NS;
      end
    end else if (ev && mr) begin
      slot = q_head[m_owner] % QD;
      q_head[m_owner]++;
      if (q_last[m_owner][slot]) begin
        m_cnt[m_owner] = (m_cnt[m_owner] + 1) % 65536;
        m_last  = m_owner;
        m_owner = -1;
      end
    end
  endtask

  task automatic do_reset();
    step('0, 1'b1, 1'b1);
    gnt_order.delete();
    beat_steps.delete();
  endtask

  task automatic test_reset();
    do_reset();
    step('0, 1'b1, 1'b0);
    n_checks++;
    if (grant !== '0 || M_AXIS_tvalid !== 1'b0 || S_AXIS_tready !== '0)
      $display("FAIL reset_state got grant=%b tvalid=%b tready=%b exp 0/0/0", grant, M_AXIS_tvalid, S_AXIS_tready);
    else n_pass++;
`ifdef AXIS_ARB_FRAME_CNT_EN
    n_checks++;
    if (frame_cnt !== '0) $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_two_frames();
    do_reset();
    add_frame(0, 4);
    add_frame(2, 4);
    repeat (12) step('1, 1'b1, 1'b0);
    n_checks++;
    if (gnt_order.size() != 2) $display("FAIL two_frames_order got=%0d grants exp=2", gnt_order.size());
    else if (gnt_order[0] !== 4'b0001 || gnt_order[1] !== 4'b0100)
      $display("FAIL two_frames_order got=%b,%b exp=0001,0100", gnt_order[0], gnt_order[1]);
    else n_pass++;
    n_checks++;
    if (beat_steps.size() != 8) $display("FAIL two_frames_beats got=%0d exp=8", beat_steps.size());
    else n_pass++;
    n_checks++;
    if (beat_steps.size() < 5 || beat_steps[4] - beat_steps[3] != 2)
      $display("FAIL two_frames_gap got=%0d beats exp spacing=2", beat_steps.size());
    else n_pass++;
  endtask

  task automatic test_rr_single();
    logic [NS-1:0] exp_order [5];
    logic          spaced;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    for (int i = 0; i < NS; i++) begin
      add_frame(i, 1);
      add_frame(i, 1);
    end
    repeat (10) step('1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= gnt_order.size()) $display("FAIL rr_order[%0d] got=none exp=%b", k, exp_order[k]);
      else if (gnt_order[k] !== exp_order[k]) $display("FAIL rr_order[%0d] got=%b exp=%b", k, gnt_order[k], exp_order[k]);
      else n_pass++;
    end
    spaced = (beat_steps.size() == 5);
    for (int k = 1; k < beat_steps.size(); k++) if (beat_steps[k] - beat_steps[k-1] != 2) spaced = 1'b0;
    n_checks++;
    if (!spaced) $display("FAIL rr_rate got=%0d beats exp=5 at 2-cycle spacing", beat_steps.size());
    else n_pass++;
  endtask

  task automatic test_owner_stall();
    do_reset();
    add_frame(0, 4);
    add_frame(1, 2);
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    repeat (3) begin
      step(4'b1110, 1'b1, 1'b0);
      #1;
      n_checks++;
      if (grant !== 4'b0001 || M_AXIS_tvalid !== 1'b0)
        $display("FAIL owner_stall got grant=%b tvalid=%b exp 0001/0", grant, M_AXIS_tvalid);
      else n_pass++;
    end
    repeat (10) step('1, 1'b1, 1'b0);
    n_checks++;
    if (gnt_order.size() != 2 || beat_steps.size() != 6)
      $display("FAIL owner_stall_total got grants=%0d beats=%0d exp 2/6", gnt_order.size(), beat_steps.size());
    else if (gnt_order[0] !== 4'b0001 || gnt_order[1] !== 4'b0010)
      $display("FAIL owner_stall_order got=%b,%b exp=0001,0010", gnt_order[0], gnt_order[1]);
    else n_pass++;
  endtask

  task automatic test_ready_stall();
    logic [DW-1:0] held;
    do_reset();
    add_frame(0, 2);
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    held = q_data[0][q_head[0] % QD];
    repeat (5) begin
      step('1, 1'b0, 1'b0);
      #1;
      n_checks++;
      if (grant !== 4'b0001 || M_AXIS_tlast !== 1'b1 || M_AXIS_tdata !== held)
        $display("FAIL ready_stall got grant=%b tlast=%b tdata=%h exp 0001/1/%h", grant, M_AXIS_tlast, M_AXIS_tdata, held);
      else n_pass++;
    end
    step('1, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (grant !== '0 || M_AXIS_tvalid !== 1'b0)
      $display("FAIL ready_release got grant=%b tvalid=%b exp 0000/0", grant, M_AXIS_tvalid);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    add_frame(0, 6);
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b1);
    #1;
    n_checks++;
    if (grant !== '0 || M_AXIS_tvalid !== 1'b0)
      $display("FAIL mid_reset got grant=%b tvalid=%b exp 0000/0", grant, M_AXIS_tvalid);
    else n_pass++;
    gnt_order.delete();
    add_frame(1, 2);
    add_frame(0, 2);
    repeat (8) step('1, 1'b1, 1'b0);
    n_checks++;
    if (gnt_order.size() == 0 || gnt_order[0] !== 4'b0001)
      $display("FAIL mid_reset_prio got=%b exp=0001", (gnt_order.size() == 0) ? 4'b0000 : gnt_order[0]);
    else n_pass++;
  endtask

`ifdef AXIS_ARB_FRAME_CNT_EN
  task automatic test_frame_cnt();
    do_reset();
    repeat (3) add_frame(1, $urandom_range(1, 3));
    repeat (20) step('1, 1'b1, 1'b0);
    #1;
    for (int i = 0; i < NS; i++) begin
      n_checks++;
      if (frame_cnt[i*16 +: 16] !== ((i == 1) ? 16'd3 : 16'd0))
        $display("FAIL frame_cnt[%0d] got=%0d exp=%0d", i, frame_cnt[i*16 +: 16], (i == 1) ? 3 : 0);
      else n_pass++;
    end
  endtask
`endif

  task automatic test_random();
    logic [NS-1:0] en;
    logic          mr;
    logic          r;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (q_tail[i] - q_head[i] < 8 && $urandom_range(0, 3) == 0) add_frame(i, $urandom_range(1, 5));
      end
      en = NS'($urandom) | NS'($urandom);
      mr = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 299) == 0);
      step(en, mr, r);
    end
`ifdef AXIS_ARB_FRAME_CNT_EN
    #1;
    for (int i = 0; i < NS; i++) begin
      n_checks++;
      if (frame_cnt[i*16 +: 16] !== 16'(m_cnt[i]))
        $display("FAIL random_frame_cnt[%0d] got=%0d exp=%0d", i, frame_cnt[i*16 +: 16], m_cnt[i]);
      else n_pass++;
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < NS; i++) begin
      q_head[i] = 0;
      q_tail[i] = 0;
      m_cnt[i]  = 0;
    end
    test_reset();
    test_two_frames();
    test_rr_single();
    test_owner_stall();
    test_ready_stall();
    test_mid_reset();
`ifdef AXIS_ARB_FRAME_CNT_EN
    test_frame_cnt();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
